// File: rtl/parking_gate_sensor_pkg.sv
// Shared types and default parameters for the parking gate beam sensor.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN_A  = 3'd1,
    EN_AB = 3'd2,
    EN_B  = 3'd3,
    EX_B  = 3'd4,
    EX_AB = 3'd5,
    EX_A  = 3'd6,
    FAULT = 3'd7
  } gate_state_e;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF  = 1000;
  localparam int unsigned CNT_W_DEF           = 10;

endpackage

// File: rtl/parking_gate_sensor_if.sv
// Gate-side signal bundle: raw beams in, passage pulses and status out.
interface parking_gate_sensor_if;
  logic sensor_a;
  logic sensor_b;
  logic car_enter;
  logic car_exit;
  logic busy;
  logic fault;

  modport master (
    output sensor_a, sensor_b,
    input  car_enter, car_exit, busy, fault
  );

  modport slave (
    input  sensor_a, sensor_b,
    output car_enter, car_exit, busy, fault
  );
endinterface

// File: rtl/parking_gate_sensor_beam_debounce.sv
// One beam input: multi-flop synchroniser followed by a level debouncer.
module beam_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   synced;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign level_o = level_q;

  // Shift the raw beam through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts the run.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (synced != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = synced;
      else                                   cnt_d   = cnt_q + CW'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/parking_gate_sensor.sv
// Gate passage detector: two debounced beams feed a direction FSM with a stuck-passage timeout.
//
// state | meaning
// IDLE  | both beams clear, no passage in progress
// EN_A  | entry started, street beam A broken
// EN_AB | entry, both beams broken
// EN_B  | entry, only lot beam B broken
// EX_B  | exit started, lot beam B broken
// EX_AB | exit, both beams broken
// EX_A  | exit, only street beam A broken
// FAULT | timeout or illegal start, waiting for both beams clear
module parking_gate_sensor
  import parking_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  parking_gate_sensor_if.slave  gate
);

  gate_state_e      state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             enter_q, enter_d;
  logic             exit_q, exit_d;
  logic             busy_q, fault_q;
  logic             a, b;
  logic [1:0]       ab;
  logic             timed;

  beam_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset_n(reset_n), .raw_i(gate.sensor_a), .level_o(a)
  );

  beam_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset_n(reset_n), .raw_i(gate.sensor_b), .level_o(b)
  );

  assign ab    = {a, b};
  assign timed = (state_q != IDLE) && (state_q != FAULT);

  // Next state from the beam pattern, then timeout override, counter and pulse decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    case (ab) 2'b10: state_d = EN_A;  2'b01: state_d = EX_B;  2'b11: state_d = FAULT; default: ; endcase
      EN_A:    case (ab) 2'b11: state_d = EN_AB; 2'b00: state_d = IDLE;  default: ; endcase
      EN_AB:   case (ab) 2'b01: state_d = EN_B;  2'b10: state_d = EN_A;  default: ; endcase
      EN_B:    case (ab) 2'b00: state_d = IDLE;  2'b11: state_d = EN_AB; default: ; endcase
      EX_B:    case (ab) 2'b11: state_d = EX_AB; 2'b00: state_d = IDLE;  default: ; endcase
      EX_AB:   case (ab) 2'b10: state_d = EX_A;  2'b01: state_d = EX_B;  default: ; endcase
      EX_A:    case (ab) 2'b00: state_d = IDLE;  2'b11: state_d = EX_AB; default: ; endcase
      FAULT:   if (ab == 2'b00) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A passage stuck in one state for TIMEOUT_CYCLES cycles is abandoned.
    if (timed && (state_d == state_q) && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)))
      state_d = FAULT;

    tmo_d = '0;
    if (timed && (state_d == state_q)) tmo_d = tmo_q + CNT_W'(1);

    enter_d = (state_q == EN_B) && (state_d == IDLE);
    exit_d  = (state_q == EX_A) && (state_d == IDLE);
  end

  // State, timeout counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      busy_q  <= (state_q != IDLE);
      fault_q <= (state_q == FAULT);
    end
  end

  assign gate.car_enter = enter_q;
  assign gate.car_exit  = exit_q;
  assign gate.busy      = busy_q;
  assign gate.fault     = fault_q;

endmodule

// File: tb/tb_parking_gate_sensor.sv
// Directed bench for parking_gate_sensor with a pulse scoreboard.
module tb_parking_gate_sensor;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  typedef struct {
    bit is_enter;
    int lo;
    int hi;
  } exp_t;

  exp_t exp_q[$];

  parking_gate_sensor_if gif ();

  parking_gate_sensor #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50), .CNT_W(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .gate(gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input logic a, input logic b);
    @(negedge clk);
    gif.sensor_a = a;
    gif.sensor_b = b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full passage; the closing release is the stimulus that predicts one pulse.
  task automatic passage(input bit enter);
    drive(enter, !enter);
    idle(15);
    chk(enter ? "entry_busy_mid" : "exit_busy_mid", int'(gif.busy), 1);
    idle(5);
    drive(1'b1, 1'b1);
    idle(20);
    drive(!enter, enter);
    idle(20);
    drive(1'b0, 1'b0);
    exp_q.push_back('{is_enter: enter, lo: cyc + 6, hi: cyc + 7});
    idle(20);
    chk(enter ? "entry_busy_end" : "exit_busy_end", int'(gif.busy), 0);
  endtask

  // Monitor: every pulse must match the oldest predicted passage, in kind and cycle window.
  always @(negedge clk) begin
    if (reset_n && (gif.car_enter || gif.car_exit)) begin
      if (gif.car_enter && gif.car_exit) begin
        n_checks++;
        n_errors++;
        $display("FAIL both_pulses: car_enter=1 and car_exit=1 together, expected at most one (cycle %0d)", cyc);
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: car_enter=%0b car_exit=%0b, expected no pulse (cycle %0d)",
                 gif.car_enter, gif.car_exit, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind_enter", int'(gif.car_enter), int'(e.is_enter));
        n_checks++;
        if (cyc < e.lo || cyc > e.hi) begin
          n_errors++;
          $display("FAIL pulse_latency: pulse at cycle %0d, expected cycle %0d..%0d", cyc, e.lo, e.hi);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int r;
    bit busy_seen;
    bit got_fault;

    cyc          = 0;
    n_checks     = 0;
    n_errors     = 0;
    reset_n      = 1'b0;
    gif.sensor_a = 1'b0;
    gif.sensor_b = 1'b0;

    idle(3);
    chk("reset_car_enter", int'(gif.car_enter), 0);
    chk("reset_car_exit",  int'(gif.car_exit),  0);
    chk("reset_busy",      int'(gif.busy),      0);
    chk("reset_fault",     int'(gif.fault),     0);
    reset_n = 1'b1;
    idle(5);
    chk("post_reset_busy", int'(gif.busy), 0);

    // 1 entry, 2 exit
    passage(1'b1);
    passage(1'b0);

    // 3 glitch on A shorter than the debounce run
    busy_seen = 1'b0;
    drive(1'b1, 1'b0);
    idle(2);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gif.busy) busy_seen = 1'b1;
    end
    chk("glitch_busy_seen", int'(busy_seen), 0);

    // 4 back-out
    drive(1'b1, 1'b0);
    idle(15);
    chk("backout_busy_mid", int'(gif.busy), 1);
    idle(5);
    drive(1'b0, 1'b0);
    idle(10);
    chk("backout_busy_end", int'(gif.busy), 0);
    chk("backout_fault",    int'(gif.fault), 0);

    // 5 timeout in EN_AB
    drive(1'b1, 1'b0);
    idle(20);
    drive(1'b1, 1'b1);
    d = cyc;
    idle(40);
    chk("timeout_fault_early", int'(gif.fault), 0);
    got_fault = 1'b0;
    for (int i = 0; i < 40 && !got_fault; i++) begin
      @(negedge clk);
      if (gif.fault) got_fault = 1'b1;
    end
    chk("timeout_fault_seen", int'(got_fault), 1);
    n_checks++;
    if (cyc < d + 57 || cyc > d + 59) begin
      n_errors++;
      $display("FAIL timeout_fault_cycle: fault rose %0d cycles after AB drive, expected 57..59", cyc - d);
    end
    chk("timeout_busy", int'(gif.busy), 1);
    if (cyc < d + 70) idle(d + 70 - cyc);
    drive(1'b0, 1'b0);
    r = cyc;
    idle(7);
    chk("fault_hold", int'(gif.fault), 1);
    idle(1);
    chk("fault_clear", int'(gif.fault), 0);
    idle(2);
    chk("fault_busy_clear", int'(gif.busy), 0);

    // 6 reset during EN_B
    drive(1'b1, 1'b0);
    idle(20);
    drive(1'b1, 1'b1);
    idle(20);
    drive(1'b0, 1'b1);
    idle(10);
    chk("pre_reset_busy", int'(gif.busy), 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_car_enter", int'(gif.car_enter), 0);
    chk("midreset_car_exit",  int'(gif.car_exit),  0);
    chk("midreset_busy",      int'(gif.busy),      0);
    chk("midreset_fault",     int'(gif.fault),     0);
    idle(3);
    reset_n = 1'b1;
    drive(1'b0, 1'b0);
    idle(30);
    chk("after_reset_busy", int'(gif.busy), 0);

    idle(10);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
